// File: rtl/weight_sched_if.sv
// Handshake and status bundle between the layer sequencer and its
// surroundings: network controller, weight buffer, DMA and S_AXIS taps.
interface weight_sched_if;
   logic       run;
   logic       abort;
   logic [2:0] layer;
   logic       start_write;
   logic       dma_req;
   logic       axis_tvalid;
   logic       axis_tready;
   logic       axis_tlast;
   logic       compute_ready;
   logic       start_read;
   logic       read_done;
   logic       layer_done;
   logic       pass_done;
   logic       busy;
   logic       timeout_err;

   // Sequencer side
   modport master (
      input  run, abort, axis_tvalid, axis_tready, axis_tlast,
             compute_ready, read_done,
      output layer, start_write, dma_req, start_read, layer_done,
             pass_done, busy, timeout_err
   );

   // Controller / buffer / DMA side
   modport slave (
      output run, abort, axis_tvalid, axis_tready, axis_tlast,
             compute_ready, read_done,
      input  layer, start_write, dma_req, start_read, layer_done,
             pass_done, busy, timeout_err
   );
endinterface

// File: rtl/weight_sched.sv
// weight_sched: per-layer sequencer for the weight buffer. For every layer
// it loads weights (start_write + DMA request until the last S_AXIS beat),
// waits for the compute array, triggers the buffer read and waits for it
// to finish. A watchdog guards the two open-ended wait states.
module weight_sched #(
   parameter int NUM_LAYERS = 6,
   parameter int TIMEOUT_W  = 20
) (
   input logic            clk,
   input logic            rst,
   weight_sched_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      WR_START,
      WR_WAIT,
      RD_WAIT,
      RD_START,
      RD_BUSY,
      LAYER_END
   } state_t;

   localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);
   // Value just below all-ones: the edge that would bring the counter to
   // all-ones is the edge that fires the timeout.
   localparam logic [TIMEOUT_W-1:0] WD_LIMIT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_t               state_q, state_d;
   logic [2:0]           layer_q, layer_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;

   logic last_beat;
   logic in_wait;
   logic wd_expired;

   assign last_beat  = bus.axis_tvalid & bus.axis_tready & bus.axis_tlast;
   assign in_wait    = (state_q == WR_WAIT) || (state_q == RD_BUSY);
   assign wd_expired = in_wait && (wd_q == WD_LIMIT);

   // Next-state, layer index, sticky error and watchdog computation
   always_comb begin
      state_d       = state_q;
      layer_d       = layer_q;
      timeout_err_d = timeout_err_q;
      wd_d          = '0;
      if (in_wait) begin
         wd_d = wd_q + 1'b1;
      end
      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.run) begin
                  state_d       = WR_START;
                  layer_d       = '0;
                  timeout_err_d = 1'b0;
               end
            end
            WR_START: begin
               state_d = WR_WAIT;
            end
            WR_WAIT: begin
               if (last_beat) begin
                  state_d = RD_WAIT;
               end else if (wd_expired) begin
                  state_d       = IDLE;
                  timeout_err_d = 1'b1;
               end
            end
            RD_WAIT: begin
               if (bus.compute_ready) begin
                  state_d = RD_START;
               end
            end
            RD_START: begin
               state_d = RD_BUSY;
            end
            RD_BUSY: begin
               if (bus.read_done) begin
                  state_d = LAYER_END;
               end else if (wd_expired) begin
                  state_d       = IDLE;
                  timeout_err_d = 1'b1;
               end
            end
            LAYER_END: begin
               if (layer_q == LAST_LAYER) begin
                  state_d = IDLE;
               end else begin
                  layer_d = layer_q + 3'd1;
                  state_d = WR_START;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously by rst low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         layer_q       <= '0;
         timeout_err_q <= 1'b0;
         wd_q          <= '0;
      end else begin
         state_q       <= state_d;
         layer_q       <= layer_d;
         timeout_err_q <= timeout_err_d;
         wd_q          <= wd_d;
      end
   end

   assign bus.layer       = layer_q;
   assign bus.start_write = (state_q == WR_START);
   assign bus.dma_req     = (state_q == WR_WAIT);
   assign bus.start_read  = (state_q == RD_START);
   assign bus.layer_done  = (state_q == LAYER_END);
   assign bus.pass_done   = (state_q == LAYER_END) && (layer_q == LAST_LAYER);
   assign bus.busy        = (state_q != IDLE);
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_weight_sched.sv
// Testbench for weight_sched: a scoreboard of expected output pulses
// (start_write, start_read, layer_done/pass_done) plus cycle-exact checks.
module tb_weight_sched;

   localparam int NUM_LAYERS = 3;
   localparam int TIMEOUT_W  = 8;

   localparam logic [1:0] EV_NONE = 2'd0;
   localparam logic [1:0] EV_SW   = 2'd1;
   localparam logic [1:0] EV_SR   = 2'd2;
   localparam logic [1:0] EV_LD   = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   weight_sched_if bus ();

   weight_sched #(
      .NUM_LAYERS(NUM_LAYERS),
      .TIMEOUT_W (TIMEOUT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [5:0] exp_q [$];

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [5:0] evCode(input logic [1:0] kind, input logic [2:0] lyr,
                                         input logic pass);
      return {kind, lyr, pass};
   endfunction

   task automatic pushExp(input logic [1:0] kind, input logic [2:0] lyr, input logic pass);
      exp_q.push_back(evCode(kind, lyr, pass));
   endtask

   task automatic observe(input logic [5:0] obs);
      logic [5:0] expv;
      if (exp_q.size() == 0) begin
         checkOutput("sb_unexpected", 32'(obs), 32'd0);
      end else begin
         expv = exp_q.pop_front();
         checkOutput("sb_event", 32'(obs), 32'(expv));
      end
   endtask

   // Pulse monitor: every observed pulse is matched against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (bus.start_write) observe(evCode(EV_SW, bus.layer, 1'b0));
         if (bus.start_read)  observe(evCode(EV_SR, bus.layer, 1'b0));
         if (bus.layer_done || bus.pass_done)
            observe(evCode(bus.layer_done ? EV_LD : EV_NONE, bus.layer, bus.pass_done));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startRun();
      bus.run = 1'b1;
      pushExp(EV_SW, 3'd0, 1'b0);
      tick();
      bus.run = 1'b0;
   endtask

   // One layer, entered with the DUT just in WR_START
   task automatic applyStimulus(input int lyr, input int hold, input bit spurious,
                                input bit do_abort);
      bit         last_layer;
      logic [2:0] l3;
      last_layer = (lyr == NUM_LAYERS - 1);
      l3         = 3'(lyr);
      checkOutput("sw_pulse", 32'(bus.start_write), 1);
      checkOutput("sw_layer", 32'(bus.layer), 32'(lyr));
      checkOutput("sw_busy", 32'(bus.busy), 1);
      bus.compute_ready = (hold == 0);
      tick();
      checkOutput("dma_req_on", 32'(bus.dma_req), 1);
      if (spurious) begin
         bus.read_done = 1'b1;
         bus.run       = 1'b1;
         tick();
         bus.read_done = 1'b0;
         bus.run       = 1'b0;
         checkOutput("spur_wr_hold", 32'(bus.dma_req), 1);
      end
      for (int b = 1; b <= 4; b++) begin
         bus.axis_tvalid = 1'b1;
         bus.axis_tready = 1'b1;
         bus.axis_tlast  = (b == 4);
         if (b == 4 && hold == 0) pushExp(EV_SR, l3, 1'b0);
         tick();
      end
      bus.axis_tvalid = 1'b0;
      bus.axis_tready = 1'b0;
      bus.axis_tlast  = 1'b0;
      checkOutput("dma_req_off", 32'(bus.dma_req), 0);
      if (hold > 0) begin
         for (int c = 0; c < hold; c++) begin
            tick();
            checkOutput("sr_held", 32'(bus.start_read), 0);
         end
         bus.compute_ready = 1'b1;
         pushExp(EV_SR, l3, 1'b0);
      end
      tick();
      checkOutput("sr_pulse", 32'(bus.start_read), 1);
      tick();
      checkOutput("sr_once", 32'(bus.start_read), 0);
      if (spurious) begin
         bus.axis_tvalid = 1'b1;
         bus.axis_tready = 1'b1;
         bus.axis_tlast  = 1'b1;
         bus.run         = 1'b1;
         tick();
         bus.axis_tvalid = 1'b0;
         bus.axis_tready = 1'b0;
         bus.axis_tlast  = 1'b0;
         bus.run         = 1'b0;
         checkOutput("spur_rd_busy", 32'(bus.busy), 1);
         checkOutput("spur_no_ld", 32'(bus.layer_done), 0);
      end
      if (do_abort) begin
         bus.abort = 1'b1;
         tick();
         bus.abort = 1'b0;
         checkOutput("abort_busy", 32'(bus.busy), 0);
         checkOutput("abort_layer", 32'(bus.layer), 32'(lyr));
         checkOutput("abort_no_ld", 32'(bus.layer_done), 0);
         tick();
         checkOutput("abort_idle", 32'(bus.busy), 0);
         return;
      end
      repeat (3) tick();
      bus.read_done = 1'b1;
      pushExp(EV_LD, l3, last_layer);
      if (!last_layer) pushExp(EV_SW, 3'(lyr + 1), 1'b0);
      tick();
      bus.read_done = 1'b0;
      checkOutput("ld_pulse", 32'(bus.layer_done), 1);
      checkOutput("pd_flag", 32'(bus.pass_done), 32'(last_layer));
      tick();
      if (last_layer) begin
         checkOutput("pass_idle_busy", 32'(bus.busy), 0);
         checkOutput("pass_layer_hold", 32'(bus.layer), 32'(lyr));
      end
   endtask

   // Main sequence
   initial begin
      bus.run           = 1'b0;
      bus.abort         = 1'b0;
      bus.axis_tvalid   = 1'b0;
      bus.axis_tready   = 1'b0;
      bus.axis_tlast    = 1'b0;
      bus.compute_ready = 1'b0;
      bus.read_done     = 1'b0;

      #2 rst = 1'b0;
      #1;
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_layer", 32'(bus.layer), 0);
      checkOutput("rst_dma", 32'(bus.dma_req), 0);
      checkOutput("rst_terr", 32'(bus.timeout_err), 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      checkOutput("idle_busy", 32'(bus.busy), 0);

      // Pass 1: straight-through, compute_ready tied high
      startRun();
      for (int l = 0; l < NUM_LAYERS; l++) applyStimulus(l, 0, 1'b0, 1'b0);

      // Pass 2: compute_ready hold on layer 0, spurious events on layer 1
      startRun();
      applyStimulus(0, 10, 1'b0, 1'b0);
      applyStimulus(1, 0, 1'b1, 1'b0);
      applyStimulus(2, 0, 1'b0, 1'b0);

      // Pass 3: abort in RD_BUSY of layer 1
      startRun();
      applyStimulus(0, 0, 1'b0, 1'b0);
      applyStimulus(1, 0, 1'b0, 1'b1);

      // run together with abort in IDLE stays idle
      bus.run   = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.run   = 1'b0;
      bus.abort = 1'b0;
      checkOutput("run_abort_idle", 32'(bus.busy), 0);
      checkOutput("run_abort_layer", 32'(bus.layer), 1);

      // Pass 4: restart after abort begins at layer 0
      startRun();
      for (int l = 0; l < NUM_LAYERS; l++) applyStimulus(l, 0, 1'b0, 1'b0);

      // Watchdog: no tlast ever arrives
      startRun();
      checkOutput("to_sw", 32'(bus.start_write), 1);
      tick();
      checkOutput("to_dma", 32'(bus.dma_req), 1);
      repeat (254) tick();
      checkOutput("to_pre_err", 32'(bus.timeout_err), 0);
      checkOutput("to_pre_busy", 32'(bus.busy), 1);
      tick();
      checkOutput("to_err", 32'(bus.timeout_err), 1);
      checkOutput("to_busy", 32'(bus.busy), 0);
      checkOutput("to_dma_off", 32'(bus.dma_req), 0);
      tick();
      checkOutput("to_sticky", 32'(bus.timeout_err), 1);
      startRun();
      checkOutput("to_clear", 32'(bus.timeout_err), 0);
      for (int l = 0; l < NUM_LAYERS; l++) applyStimulus(l, 0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of WR_WAIT
      startRun();
      tick();
      checkOutput("rst_dma_pre", 32'(bus.dma_req), 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_dma", 32'(bus.dma_req), 0);
      checkOutput("arst_busy", 32'(bus.busy), 0);
      checkOutput("arst_sw", 32'(bus.start_write), 0);
      checkOutput("arst_layer", 32'(bus.layer), 0);
      checkOutput("arst_terr", 32'(bus.timeout_err), 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      checkOutput("post_rst_idle", 32'(bus.busy), 0);
      checkOutput("post_rst_dma", 32'(bus.dma_req), 0);

      tick();
      checkOutput("sb_drain", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_sched.md
# weight_sched

Layer sequencer for the weight buffer. Per layer it drives the buffer's `layer` select, pulses `start_write` and requests the weight stream from DMA, and detects load completion from the S_AXIS handshake. It then waits for the compute array, pulses `start_read`, and collects `read_done`. It sits between the top-level network controller and the weight buffer, and runs layers 0..NUM_LAYERS-1 once per `run`.

## Interface
- NUM_LAYERS, 6, layers per pass; legal range 1..8.
- TIMEOUT_W, 20, watchdog counter width; timeout fires after 2^TIMEOUT_W−1 wait cycles.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- run  in  1  pulse; starts a pass at layer 0 (honoured in IDLE only).
- abort  in  1  level/pulse; returns to IDLE next cycle from any state.
- layer  out  3  current layer index to weight buffer.
- start_write  out  1  one-cycle pulse to weight-buffer writer.
- dma_req  out  1  level; asks DMA to stream current layer's weights.
- axis_tvalid, axis_tready, axis_tlast  in  1 each  passive taps of weight S_AXIS channel.
- compute_ready  in  1  level; compute array can accept next layer's weights.
- start_read  out  1  one-cycle pulse to weight-buffer reader.
- read_done  in  1  pulse from weight-buffer reader.
- layer_done  out  1  one-cycle pulse per completed layer.
- pass_done  out  1  one-cycle pulse after last layer.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, WR_START, WR_WAIT, RD_WAIT, RD_START, RD_BUSY, LAYER_END.
- IDLE: `run`=1 → WR_START; `layer`←0, `timeout_err`←0.
- WR_START (1 cycle): `start_write`=1; `layer` already valid this cycle → WR_WAIT.
- WR_WAIT: `dma_req`=1. Last beat = tvalid&tready&tlast. Last beat → RD_WAIT.
- RD_WAIT: `compute_ready`=1 → RD_START.
- RD_START (1 cycle): `start_read`=1 → RD_BUSY.
- RD_BUSY: `read_done`=1 → LAYER_END.
- LAYER_END (1 cycle): `layer_done`=1.
  - If `layer`==NUM_LAYERS−1: `pass_done`=1 same cycle → IDLE; `layer` holds.
  - Else: `layer`←layer+1 → WR_START.
- Watchdog: counter cleared on entry to WR_WAIT and RD_BUSY; increments each cycle spent in those states. Reaching all-ones → `timeout_err`←1 and state → IDLE; no done pulses.
- `abort` has top priority: any state → IDLE next cycle. No `layer_done`/`pass_done` pulse; `dma_req` drops; `layer` holds.
- `run` and `abort` together in IDLE: abort wins; stay IDLE.
- Ignored events:
  - `run` outside IDLE.
  - Last beat outside WR_WAIT.
  - `read_done` outside RD_BUSY.
  - `compute_ready` outside RD_WAIT.
- All outputs registered, i.e. decoded from the state register or held in registers; no combinational input→output paths.

## Timing
- Reset (rst=0, async): state IDLE; layer=0; all pulses, dma_req, busy and timeout_err = 0.
- `run` at cycle t → WR_START at t+1: start_write=1, busy=1. dma_req=1 from t+2.
- Last beat at cycle t → dma_req=0 at t+1 (RD_WAIT).
- compute_ready already high at entry to RD_WAIT → start_read exactly 1 cycle after RD_WAIT entry.
- read_done at t → layer_done at t+1. Next layer's start_write at t+2 with incremented layer.
- Minimum per-layer overhead beyond load/read: 4 cycles (WR_START, RD_WAIT, RD_START, LAYER_END).
- Timeout: 2^TIMEOUT_W−1 cycles after wait-state entry, timeout_err=1 and busy=0 on the same edge.

## Test plan
- NUM_LAYERS=3, run, each load = 4 beats with tlast on beat 4, compute_ready tied 1, read_done 5 cycles after start_read:
  - Required: 3 start_write pulses with layer 0,1,2; 3 start_read; 3 layer_done; 1 pass_done coincident with the third; then busy=0.
- compute_ready held 0 for 10 cycles after load: start_read absent during hold; asserted 1 cycle after compute_ready rises.
- abort during RD_BUSY of layer 1: IDLE next cycle; busy=0; no layer_done; layer stays 1. Subsequent run restarts at layer 0.
- TIMEOUT_W=8, tlast never sent: timeout_err=1 and busy=0 exactly 255 cycles after WR_WAIT entry. Next run clears timeout_err.
- Spurious events: read_done in WR_WAIT, tlast beat in RD_BUSY, run mid-pass → no state change, no extra pulses.
- rst asserted mid-WR_WAIT with dma_req=1: all outputs 0 immediately, without a clock edge. After release, IDLE until run.
